// File: rtl/if_id.sv
// ---------------------------------------------------------------------------
// cpu_pkg / if_id : IF/ID pipeline register.
//
// cpu_pkg holds the datapath width and the fetch-to-decode payload struct.
//
// if_id registers one fetched instruction for the decode stage.
//   Ports:
//     clock     in   rising-edge clock, the only clock
//     reset     in   asynchronous active-low reset, released synchronously
//     data_in   in   if_id_data_t {pc_address, instruc} from fetch
//     valid_in  in   data_in is a real fetched instruction
//     stall     in   hold current contents (hazard unit)
//     flush     in   load a bubble instead of the fetched instruction
//     data_out  out  registered {pc_address, instruc} to decode
//     valid_out out  data_out is a real instruction
//
// Valid semantics: there is no back-pressure handshake. valid_in qualifies
// data_in on every edge where the register loads; stall is the only hold
// mechanism and valid_out qualifies data_out for the whole cycle.
//
// Priority on each rising edge: reset > flush > stall > normal capture.
// Every output comes straight from a flop.
// ---------------------------------------------------------------------------
package cpu_pkg;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc_address;
    logic [XLEN-1:0] instruc;
  } if_id_data_t;
endpackage

module if_id
  import cpu_pkg::*;
#(
  // Must match cpu_pkg::XLEN, which fixes the struct field widths.
  parameter int              XLEN      = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  if_id_data_t data_in,
  input  logic        valid_in,
  input  logic        stall,
  input  logic        flush,
  output if_id_data_t data_out,
  output logic        valid_out
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (flush) begin
      // The bubble keeps the fetched PC so decode still sees a coherent
      // address; only the instruction is replaced and the slot invalidated.
      // Flush wins over stall: a redirected front end must not keep the
      // wrong-path instruction alive.
      data_out.pc_address <= data_in.pc_address;
      data_out.instruc    <= NOP_INSTR;
      valid_out           <= 1'b0;
    end else if (!stall) begin
      // Fields are captured even when valid_in is low.
      data_out  <= data_in;
      valid_out <= valid_in;
    end
  end

endmodule

// File: tb/tb_if_id.sv
// ---------------------------------------------------------------------------
// tb_if_id : directed self-checking bench for if_id.
//   Inputs are driven 1 time unit after a rising edge; outputs are sampled
//   1 time unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_if_id;
  import cpu_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // clock / reset
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  if_id_data_t data_in;
  logic        valid_in;
  logic        stall;
  logic        flush;
  if_id_data_t data_out;
  logic        valid_out;

  always #5 clock = ~clock;

  if_id #(.XLEN(32), .NOP_INSTR(NOP)) dut (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .stall     (stall),
    .flush     (flush),
    .data_out  (data_out),
    .valid_out (valid_out)
  );

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [64:0] exp_q[$];

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // Compares the whole output bundle {pc, instr, valid}.
  task automatic check_out(input string tag, input logic [31:0] pc,
                           input logic [31:0] ins, input logic v);
    check(tag, {data_out.pc_address, data_out.instruc, valid_out}, {pc, ins, v});
  endtask

  // driver tasks
  task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic v,
                       input logic st, input logic fl);
    data_in.pc_address = pc;
    data_in.instruc    = ins;
    valid_in           = v;
    stall              = st;
    flush              = fl;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset state, held across a clock edge.
    #2;
    check_out("reset_async", 32'h0, 32'h0, 1'b0);
    drive(32'hDEAD, 32'hBEEF, 1'b1, 1'b0, 1'b0);
    step();
    check_out("reset_hold_edge", 32'h0, 32'h0, 1'b0);

    // Release and first capture.
    reset = 1'b1;
    drive(32'd42010, 32'd43210, 1'b1, 1'b0, 1'b0);
    step();
    check_out("first_capture", 32'd42010, 32'd43210, 1'b1);

    // Async reset between edges.
    #2;
    reset = 1'b0;
    #1;
    check_out("reset_mid_cycle", 32'h0, 32'h0, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // Stall hold.
    step();
    drive(32'h100, 32'h0050_0093, 1'b1, 1'b0, 1'b0);
    step();
    check_out("stall_load", 32'h100, 32'h0050_0093, 1'b1);
    drive(32'h104, 32'h00A0_0113, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("stall_hold", 32'h100, 32'h0050_0093, 1'b1);
    end
    stall = 1'b0;
    step();
    check_out("stall_release", 32'h104, 32'h00A0_0113, 1'b1);

    // valid_in low still captures fields.
    drive(32'h1F0, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    step();
    check_out("invalid_capture", 32'h1F0, 32'h1234_5678, 1'b0);

    // Flush.
    drive(32'h200, 32'h00C0_0193, 1'b1, 1'b0, 1'b1);
    step();
    check_out("flush_bubble", 32'h200, NOP, 1'b0);

    // Stall on an invalid entry holds valid_out low too.
    drive(32'h204, 32'h0000_0001, 1'b1, 1'b1, 1'b0);
    step();
    check_out("stall_hold_bubble", 32'h200, NOP, 1'b0);

    // Stall and flush together: flush wins.
    drive(32'h300, 32'h0000_00EF, 1'b1, 1'b0, 1'b0);
    step();
    check_out("pre_priority_load", 32'h300, 32'h0000_00EF, 1'b1);
    drive(32'h304, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
    step();
    check_out("stall_flush_priority", 32'h304, NOP, 1'b0);

    // Reset during flush forces zeros, also across an edge.
    drive(32'h400, 32'hAAAA_5555, 1'b1, 1'b0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_out("reset_over_flush", 32'h0, 32'h0, 1'b0);
    step();
    check_out("reset_over_flush_edge", 32'h0, 32'h0, 1'b0);
    reset = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();

    // Latency: 100 random entries, each output equals the input one edge earlier.
    for (int i = 0; i < 100; i++) begin
      logic [31:0] pc;
      logic [31:0] ins;
      logic        v;
      pc  = $urandom;
      ins = $urandom;
      v   = 1'($urandom_range(0, 1));
      drive(pc, ins, v, 1'b0, 1'b0);
      exp_q.push_back({pc, ins, v});
      step();
      check("stream", {data_out.pc_address, data_out.instruc, valid_out}, exp_q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog keeps the run bounded.
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
